// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings and FSM states.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Radix-2 restoring divider core working on unsigned magnitudes.
// One quotient bit per step; quotient/remainder outputs show the value
// after the step taken in the current cycle, so the caller can commit
// the final result on the same edge as the last step.
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         start,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] rem_reg, rem_next;
    logic [W-1:0] quo_reg, quo_next;
    logic [W-1:0] dsr_reg;
    logic [W:0]   trial;

    // Partial remainder shifted left by one dividend bit, minus the divisor.
    assign trial = {rem_reg, quo_reg[W-1]} - {1'b0, dsr_reg};

    // Keep the subtraction when it did not borrow, otherwise restore.
    always_comb begin
        rem_next = {rem_reg[W-2:0], quo_reg[W-1]};
        quo_next = {quo_reg[W-2:0], 1'b0};
        if (!trial[W]) begin
            rem_next = trial[W-1:0];
            quo_next = {quo_reg[W-2:0], 1'b1};
        end
    end

    // Load operands on start, otherwise advance one bit per step.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            dsr_reg <= divisor;
        end else if (step) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
        end
    end

    assign quotient  = quo_next;
    assign remainder = rem_next;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit beside the EX stage.
// Optional feature: define MULDIV_DIV_EARLY_OUT_EN to finish a divide in one
// cycle when the divisor is non-zero and |dividend| < |divisor|.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_W-1:0]     hi_reg, hi_next, lo_reg, lo_next;
    logic                  done_reg, done_next;
    logic                  accept, mul_load, div_start, mul_signed, div_signed;
    logic                  a_neg, b_neg, q_neg_reg, r_neg_reg;
    logic [DATA_W-1:0]     a_mag, b_mag, quo, rem;
    logic [DATA_W-1:0]     div_hi_res, div_lo_res;
    logic [CNT_W-1:0]      div_cnt_init;
    logic [2*DATA_W-1:0]   a_ext, b_ext, prod_comb, prod_out;
    logic [2*DATA_W-1:0]   prod_pipe [MUL_STAGES];

    assign busy      = (state_reg != IDLE);
    assign req_ready = !busy && !cancel;
    assign accept    = req_valid && req_ready;
    assign mul_load  = accept && (op == OP_MULT || op == OP_MULTU);
    assign div_start = accept && (op == OP_DIV || op == OP_DIVU);

    // Multiplier: sign-extend to full width so one unsigned multiply serves both forms.
    assign mul_signed = (op == OP_MULT);
    assign a_ext      = {{DATA_W{mul_signed & src_a[DATA_W-1]}}, src_a};
    assign b_ext      = {{DATA_W{mul_signed & src_b[DATA_W-1]}}, src_b};
    assign prod_comb  = a_ext * b_ext;

    // The first stage captures the product of the accepted operands; later stages only delay it.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_STAGES; gi++) begin : g_mul_pipe
            if (gi == 0) begin : g_first
                // Capture the product when a multiply is accepted.
                always_ff @(posedge clk) begin
                    if (mul_load) prod_pipe[0] <= prod_comb;
                end
            end else begin : g_rest
                // Delay stage so the result lands in the terminal cycle.
                always_ff @(posedge clk) begin
                    prod_pipe[gi] <= prod_pipe[gi-1];
                end
            end
        end
    endgenerate
    assign prod_out = prod_pipe[MUL_STAGES-1];

    // Divider operates on magnitudes; signs are restored at commit time.
    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed && src_a[DATA_W-1];
    assign b_neg      = div_signed && src_b[DATA_W-1];
    assign a_mag      = a_neg ? -src_a : src_a;
    assign b_mag      = b_neg ? -src_b : src_b;

    div_iter #(.W(DATA_W)) u_div (
        .clk       (clk),
        .start     (div_start),
        .step      (state_reg == DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    // Remember result signs for the divide in flight.
    always_ff @(posedge clk) begin
        if (div_start) begin
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
        end
    end

`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic              early_reg, early_next;
    logic [DATA_W-1:0] early_hi_reg;

    assign early_next   = (b_mag != '0) && (a_mag < b_mag);
    assign div_cnt_init = early_next ? CNT_W'(1) : CNT_W'(DATA_W);

    // Trivial divides skip the iteration: quotient 0, remainder is the dividend itself.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            early_reg <= 1'b0;
        end else if (div_start) begin
            early_reg    <= early_next;
            early_hi_reg <= src_a;
        end
    end

    assign div_hi_res = early_reg ? early_hi_reg : (r_neg_reg ? -rem : rem);
    assign div_lo_res = early_reg ? '0 : (q_neg_reg ? -quo : quo);
`else
    assign div_cnt_init = CNT_W'(DATA_W);
    assign div_hi_res   = r_neg_reg ? -rem : rem;
    assign div_lo_res   = q_neg_reg ? -quo : quo;
`endif

    // Next-state, counter and HI/LO update; cancel beats the terminal write.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_next = MUL;
                            cnt_next   = CNT_W'(MUL_STAGES);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_next = DIV;
                            cnt_next   = div_cnt_init;
                        end
                        OP_MTHI: hi_next = src_a;
                        OP_MTLO: lo_next = src_a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(1)) begin
                    hi_next    = prod_out[2*DATA_W-1:DATA_W];
                    lo_next    = prod_out[DATA_W-1:0];
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DIV: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(1)) begin
                    hi_next    = div_hi_res;
                    lo_next    = div_lo_res;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter and architectural register update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: arithmetic reference model compared
// every cycle, plus directed vectors with literal expectations.
// Honours MULDIV_DIV_EARLY_OUT_EN when defined.
module tb_hilo_muldiv;

    localparam int W  = 32;
    localparam int MS = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          cancel = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          req_ready, busy, done;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.DATA_W(W), .MUL_STAGES(MS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 64'(x * y);
    endfunction

    function automatic longint mag(input logic s, input logic [31:0] a);
        longint v;
        v = s ? longint'($signed(a)) : longint'(a);
        return (v < 0) ? -v : v;
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, q, r;
        logic an, bn;
        an = s && a[31];
        bn = s && b[31];
        ma = mag(s, a);
        mb = mag(s, b);
        if (mb == 0) begin
            q = 64'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (an ^ bn) q = -q;
        if (an) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int div_latency(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EARLY_OUT_EN
        if (mag(s, b) != 0 && mag(s, a) < mag(s, b)) return 1;
`endif
        return W;
    endfunction

    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [63:0]  m_res = '0;
    int           m_rem = 0;
    logic         m_done = 1'b0;

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!resetn) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_rem <= 0;
        end else if (m_rem > 0) begin
            if (cancel) begin
                m_rem <= 0;
            end else if (m_rem == 1) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_done <= 1'b1;
                m_rem  <= 0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end else if (req_valid && !cancel) begin
            case (op)
                3'b000: begin m_res <= mul_model(1'b1, src_a, src_b); m_rem <= MS; end
                3'b001: begin m_res <= mul_model(1'b0, src_a, src_b); m_rem <= MS; end
                3'b010: begin m_res <= div_model(1'b1, src_a, src_b); m_rem <= div_latency(1'b1, src_a, src_b); end
                3'b011: begin m_res <= div_model(1'b0, src_a, src_b); m_rem <= div_latency(1'b0, src_a, src_b); end
                3'b100: m_hi <= src_a;
                3'b101: m_lo <= src_a;
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_busy",  32'(busy),      32'(m_rem > 0));
        chk("cyc_done",  32'(done),      32'(m_done));
        chk("cyc_ready", 32'(req_ready), 32'((m_rem == 0) && !cancel));
        chk("cyc_hi",    hi,             m_hi);
        chk("cyc_lo",    lo,             m_lo);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] eh, input logic [31:0] el);
        int found;
        found = -1;
        op = o; src_a = a; src_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 100 && found < 0; k++) begin
            if (done === 1'b1) found = k;
            else tick();
        end
        chk({name, "_done_cycle"}, 32'(found), 32'(exp_cyc));
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        $display("op %s a=%h b=%h done_cycle=%0d hi=%h lo=%h", name, a, b, found, hi, lo);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int early_cyc;
        resetn = 1'b0;
        tick(); tick(); tick();
        chk("rst_hi",   hi,          32'h0);
        chk("rst_lo",   lo,          32'h0);
        chk("rst_busy", 32'(busy),   32'h0);
        chk("rst_done", 32'(done),   32'h0);
        resetn = 1'b1;
        tick();

        run_op("mult_neg1x2",  3'b000, 32'hFFFF_FFFF, 32'h2, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max_x2", 3'b001, 32'hFFFF_FFFF, 32'h2, 3, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_min_sq",  3'b000, 32'h8000_0000, 32'h8000_0000, 3, 32'h4000_0000, 32'h0);
        run_op("mult_m3x5",    3'b000, 32'hFFFF_FFFD, 32'h5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7_2",     3'b010, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2",     3'b011, 32'h7, 32'h2, 33, 32'h1, 32'h3);
        run_op("div_7_m2",     3'b010, 32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD);
        run_op("div_m8_m3",    3'b010, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFE, 32'h2);
        run_op("divu_5_0",     3'b011, 32'h5, 32'h0, 33, 32'h5, 32'hFFFF_FFFF);
        run_op("div_m7_0",     3'b010, 32'hFFFF_FFF9, 32'h0, 33, 32'hFFFF_FFF9, 32'h1);
        run_op("div_min_m1",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
`ifdef MULDIV_DIV_EARLY_OUT_EN
        early_cyc = 2;
`else
        early_cyc = 33;
`endif
        run_op("divu_3_10",    3'b011, 32'h3, 32'hA, early_cyc, 32'h3, 32'h0);

        // MTHI / MTLO in idle
        op = 3'b100; src_a = 32'h1234; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mthi_hi",   hi,        32'h1234);
        chk("mthi_lo",   lo,        32'h0);
        chk("mthi_busy", 32'(busy), 32'h0);
        $display("op mthi a=1234 hi=%h lo=%h busy=%b", hi, lo, busy);
        op = 3'b101; src_a = 32'h5678; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi", hi, 32'h1234);
        $display("op mtlo a=5678 hi=%h lo=%h", hi, lo);

        // MTLO held while a divide is busy
        op = 3'b010; src_a = 32'd100; src_b = 32'd3; req_valid = 1'b1;
        tick();
        op = 3'b101; src_a = 32'hABCD;
        chk("mtlo_busy_ready", 32'(req_ready), 32'h0);
        chk("mtlo_busy_lo",    lo,             32'h5678);
        k = 1;
        while (req_ready !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("mtlo_wait_cycle", 32'(k), 32'd33);
        chk("div100_3_lo", lo, 32'd33);
        chk("div100_3_hi", hi, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("mtlo_after_lo", lo, 32'hABCD);
        chk("mtlo_after_hi", hi, 32'd1);
        $display("op mtlo_after_div wait=%0d hi=%h lo=%h", k, hi, lo);

        // Cancel mid-divide in cycle 10
        op = 3'b010; src_a = 32'd100; src_b = 32'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'h0);
        n = 0;
        repeat (40) begin
            if (done === 1'b1) n++;
            tick();
        end
        chk("cancel_no_done", 32'(n), 32'h0);
        chk("cancel_hi", hi, 32'd1);
        chk("cancel_lo", lo, 32'hABCD);
        $display("op div_cancel_c10 busy=%b dones=%0d hi=%h lo=%h", busy, n, hi, lo);

        // Cancel in the terminal cycle
        op = 3'b011; src_a = 32'd7; src_b = 32'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (31) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("term_cancel_busy", 32'(busy), 32'h0);
        chk("term_cancel_done", 32'(done), 32'h0);
        chk("term_cancel_hi",   hi,        32'd1);
        chk("term_cancel_lo",   lo,        32'hABCD);
        $display("op divu_cancel_term busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);

        // Cancel in idle drops a pending MTHI
        op = 3'b100; src_a = 32'hDEAD; req_valid = 1'b1; cancel = 1'b1;
        tick();
        cancel = 1'b0; req_valid = 1'b0;
        chk("idle_cancel_hi", hi, 32'd1);
        $display("op mthi_cancel hi=%h", hi);

        // Reset in cycle 5 of a divide
        op = 3'b010; src_a = 32'd100; src_b = 32'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("midrst_hi",   hi,        32'h0);
        chk("midrst_lo",   lo,        32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        $display("op div_reset_c5 hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);

        run_op("mult_3x5_after_rst", 3'b000, 32'd3, 32'd5, 3, 32'h0, 32'hF);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
